// File: rtl/ycbcr2rgb_pipe.sv
// YCbCr (BT.601 full range) to RGB converter, 3-stage valid/ready pipeline.
// Optional saturation counter enabled by defining YCBCR2RGB_SAT_CNT_EN.
module ycbcr2rgb_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data
`ifdef YCBCR2RGB_SAT_CNT_EN
  ,
  input  logic        sat_clr,
  output logic [15:0] sat_cnt
`endif
);
  localparam int AW = 25;
  localparam logic signed [AW-1:0] KR  = 25'sd11485;
  localparam logic signed [AW-1:0] KGB = 25'sd2819;
  localparam logic signed [AW-1:0] KGR = 25'sd5850;
  localparam logic signed [AW-1:0] KB  = 25'sd14516;

  logic                 adv;
  logic [2:0]           vld_pipe;
  logic signed [AW-1:0] cb_off, cr_off, y_sc;
  logic signed [AW-1:0] s1_y, s1_r, s1_gb, s1_gr, s1_b;
  logic signed [AW-1:0] s2_r, s2_g, s2_b;
  logic signed [AW-1:0] rnd_r, rnd_g, rnd_b;

  function automatic logic signed [AW-1:0] rnd13(input logic signed [AW-1:0] s);
    return (s + 25'sd4096) >>> 13;
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [AW-1:0] v);
    if (v < 25'sd0)        return 8'd0;
    else if (v > 25'sd255) return 8'hFF;
    else                   return v[7:0];
  endfunction

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[2];

  assign cb_off = $signed({17'd0, in_data[15:8]}) - 25'sd128;
  assign cr_off = $signed({17'd0, in_data[23:16]}) - 25'sd128;
  assign y_sc   = $signed({4'd0, in_data[7:0], 13'd0});

  assign rnd_r = rnd13(s2_r);
  assign rnd_g = rnd13(s2_g);
  assign rnd_b = rnd13(s2_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      out_data <= '0;
      s1_y     <= '0;
      s1_r     <= '0;
      s1_gb    <= '0;
      s1_gr    <= '0;
      s1_b     <= '0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[1:0], in_valid};
      if (in_valid) begin
        s1_y  <= y_sc;
        s1_r  <= KR * cr_off;
        s1_gb <= KGB * cb_off;
        s1_gr <= KGR * cr_off;
        s1_b  <= KB * cb_off;
      end
      if (vld_pipe[0]) begin
        s2_r <= s1_y + s1_r;
        s2_g <= s1_y - s1_gb - s1_gr;
        s2_b <= s1_y + s1_b;
      end
      if (vld_pipe[1])
        out_data <= {clamp8(rnd_b), clamp8(rnd_g), clamp8(rnd_r)};
    end
  end

`ifdef YCBCR2RGB_SAT_CNT_EN
  logic s3_sat;
  logic sat_any;

  function automatic logic oor(input logic signed [AW-1:0] v);
    return (v < 25'sd0) || (v > 25'sd255);
  endfunction

  assign sat_any = oor(rnd_r) || oor(rnd_g) || oor(rnd_b);

  // s3_sat travels with out_data; the count uses the flag of the pixel leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_sat  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (adv && vld_pipe[1])
        s3_sat <= sat_any;
      if (sat_clr)
        sat_cnt <= '0;
      else if (out_valid && out_ready && s3_sat && sat_cnt != 16'hFFFF)
        sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/ycbcr2rgb_pipe.md
YCBCR2RGB_PIPE -- requirements
Module: ycbcr2rgb_pipe

Interface
REQ-001 SHALL have clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have in_valid, input, 1 bit: in_data holds a valid pixel.
REQ-004 SHALL have in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-005 SHALL have in_data, input, 24 bits, packed {Cr[23:16], Cb[15:8], Y[7:0]}, unsigned, Cb/Cr offset 128.
REQ-006 SHALL have out_valid, output, 1 bit: out_data holds a valid pixel.
REQ-007 SHALL have out_ready, input, 1 bit: sink accepts out_data this cycle.
REQ-008 SHALL have out_data, output, 24 bits, packed {B[23:16], G[15:8], R[7:0]}, unsigned.
REQ-009 SHALL have sat_clr, input, 1 bit, and sat_cnt, output, 16 bits, only when YCBCR2RGB_SAT_CNT_EN is defined.

Function
REQ-010 SHALL use coefficients scaled by 2^13: KR=11485 (1.402), KGB=2819 (0.344136), KGR=5850 (0.714136), KB=14516 (1.772).
REQ-011 SHALL form signed Cb'=Cb-128 and Cr'=Cr-128 (9-bit signed) and Y scaled as Y*8192.
REQ-012 SHALL compute R=Y*8192+KR*Cr', G=Y*8192-KGB*Cb'-KGR*Cr', B=Y*8192+KB*Cb' in signed accumulators of at least 24 bits with no overflow.
REQ-013 SHALL round each sum by adding 4096, then arithmetic shift right by 13.
REQ-014 SHALL clamp each rounded result: <0 -> 0, >255 -> 255, else low 8 bits.
REQ-015 SHALL be a 3-stage pipeline: S1 registers offsets/products, S2 registers sums, S3 registers rounded/clamped output; each stage carries a valid bit.
REQ-016 SHALL advance all stages together when advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-017 SHALL capture in_data into S1 only when in_valid && in_ready; a stage with no incoming valid SHALL load valid=0.
REQ-018 SHALL hold all stage registers and out_data unchanged while advance=0 (out_valid && !out_ready).
REQ-019 SHALL give latency of exactly 3 cycles from accepted input to out_valid when out_ready is held 1, sustaining 1 pixel/cycle.
REQ-020 SHALL preserve pixel order with no loss or duplication under any in_valid/out_ready pattern.
REQ-021 SHALL keep out_data stable whenever out_valid=1 and out_ready=0.

Reset
REQ-022 SHALL, on rst assertion, immediately clear all stage valid bits, out_valid=0, out_data=0, and sat_cnt=0 if present.
REQ-023 SHALL discard in-flight pixels on reset mid-operation; no output from pre-reset pixels after rst deasserts.
REQ-024 SHALL drive in_ready=1 during and immediately after reset (pipeline empty).

Configuration
REQ-025 SHALL, with YCBCR2RGB_SAT_CNT_EN defined, provide a saturation flag per pixel, set when any channel was clamped (REQ-014 out-of-range branch), carried with S3.
REQ-026 SHALL, with YCBCR2RGB_SAT_CNT_EN defined, increment sat_cnt by 1 on each out_valid && out_ready handshake whose pixel flag is 1, saturating at 16'hFFFF.
REQ-027 SHALL, with YCBCR2RGB_SAT_CNT_EN defined, give sat_clr priority: sat_clr=1 loads sat_cnt=0 that cycle regardless of handshake.
REQ-028 SHALL, without YCBCR2RGB_SAT_CNT_EN, omit sat_clr, sat_cnt and flag logic; datapath behaviour identical.

Verification
REQ-029 SHALL cover neutral grey: in {Cr=128,Cb=128,Y=128}, out_ready=1 -> out_data {B=128,G=128,R=128} exactly 3 cycles later, no sat count.
REQ-030 SHALL cover high clamp: {Cr=255,Cb=128,Y=255} -> R=255, G=164, B=255; sat_cnt increments by 1.
REQ-031 SHALL cover low clamp: {Cr=0,Cb=0,Y=0} -> R=0, G=135, B=0; and {Cr=0,Cb=255,Y=0} -> R=0, G=48, B=225; each increments sat_cnt.
REQ-032 SHALL cover backpressure: stream 10 pixels with out_ready toggled randomly -> in_ready low when blocked, output sequence equals golden model in order, out_data stable while stalled.
REQ-033 SHALL cover reset mid-stream: assert rst with 3 pixels in flight -> out_valid=0 at once, no stale pixels emerge after release, in_ready=1.
REQ-034 SHALL cover counter: 65540 saturating pixels -> sat_cnt holds 16'hFFFF; sat_clr coincident with a saturating handshake -> sat_cnt=0.
